imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Registered, parametrised immediate-generation stage between decode and execute.
//  Extracts and extends the immediate from instr[31:7] for XLEN 32 or 64.
//  Adds CSR zimm (Z) and shift-amount (SH) modes, an illegal-type flag and a passthrough tag.
//  Buffers results in a 2-entry FIFO behind valid/ready handshakes, with flush.
// PARAMETERS
//  XLEN   64  datapath width; legal values are 32 or 64 only. Any other value is an elaboration error.
//  TAG_W  64  width of the opaque tag (normally the PC) carried alongside each result.
// PORTS
//  clk         in   1                  clock; all state updates on the rising edge.
//  rst_n       in   1                  reset, asynchronous, active-low.
//  flush       in   1                  discard all buffered entries.
//  in_valid    in   1                  instr, instr_type and in_tag are valid.
//  in_ready    out  1                  stage can accept an entry.
//  instr       in   25                 instruction bits [31:7].
//  instr_type  in   `INSTR_TYPE_BUS    format select: I/S/B/U/J/R/Z/SH.
//  in_tag      in   TAG_W              tag carried with the entry.
//  out_valid   out  1                  head entry is valid.
//  out_ready   in   1                  consumer accepts the head entry.
//  simm        out  XLEN               extended immediate of the head entry.
//  illegal     out  1                  head entry had an unknown instr_type.
//  out_tag     out  TAG_W              tag of the head entry.
// BEHAVIOUR
//  Reset: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1; simm, out_tag, illegal read 0.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  in_ready = (count != 2); it depends only on registered count, never on out_ready.
//  out_valid = (count != 0). Payload outputs are driven from mem[rd_ptr], or 0 when empty.
//  Latency: an entry pushed in cycle N is visible at the output in N+1; throughput is 1/cycle.
//  Push and pop in the same cycle: count is unchanged and both pointers advance (1-bit wrap).
//  When full, in_ready=0, so no push can occur.
//  Ordering is strictly FIFO. The head entry and its payload hold stable while out_ready=0.
//  flush=1: count, rd_ptr and wr_ptr go to 0 next cycle.
//   Flush overrides a push or pop in the same cycle, so the pushed entry is dropped.
//  Async reset mid-transfer: all entries are lost and outputs go to reset values immediately.
//  Immediate is computed combinationally at push time and stored. sx(v) = sign-extend v to XLEN:
//   I:  sx(instr[31:20])
//   S:  sx({instr[31:25],instr[11:7]})
//   B:  sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//   U:  sx({instr[31:12],12'h000}); for XLEN=32 this value is used as-is.
//   J:  sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//   Z:  zero-extend instr[19:15] (CSR zimm).
//   SH: zero-extend instr[25:20] when XLEN=64; instr[24:20] when XLEN=32.
//   R:  0, illegal=0.
//   Any other encoding: simm=0, illegal=1.
//  Widths: sign-extension count = XLEN minus field width, computed with localparams.
//   No hard-coded 52/43/32 constants.
// STRUCTURE
//  common.v gains `Z_TYPE and `SH_TYPE codes; `INSTR_TYPE_BUS is widened if required.
//   Existing codes keep their values.
//  XLEN-dependent shamt width is a localparam inside this module.
//  Sub-module imm_extract (combinational, parametrised by XLEN) produces simm and illegal.
//  The FIFO control (count, pointers, 2x{XLEN+1+TAG_W} storage) lives in the top.
// TESTING (XLEN=64 unless noted; out_ready=1 unless noted)
//  1. I: instr=0xFFF00093>>7, type I -> next cycle simm=0xFFFF_FFFF_FFFF_FFFF, illegal=0.
//  2. B: 0xFE000EE3 -> simm=0xFFFF_FFFF_FFFF_FFFC.
//     U: 0x800000B7 -> 0xFFFF_FFFF_8000_0000; with XLEN=32 -> 0x8000_0000.
//  3. Z: instr[19:15]=5'h1F, type Z -> simm=0x1F.
//     SH: instr[25:20]=6'h3F, type SH -> simm=0x3F.
//     Unknown type -> simm=0, illegal=1.
//  4. Backpressure: out_ready=0, offer tags 1,2,3 back-to-back.
//     -> in_ready drops after 2 pushes; tag 3 is held by the producer.
//     -> Release out_ready: tags emerge 1,2,3 in order; head is stable while stalled.
//  5. Full with simultaneous pop: at count=2, out_ready=1 pops and count becomes 1.
//     Next cycle a push and pop together keep count=1 with the correct pointer wrap.
//  6. flush with in_valid=1 and count=2 -> next cycle out_valid=0, in_ready=1, pushed entry dropped.
//     Assert rst_n=0 mid-stream -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared types and constants for the immediate-generation stage.
package imm_gen_stage_pkg;

  // Format-select bus width; four bits leave room for unknown encodings.
  localparam int INSTR_TYPE_W = 4;

  // Format codes.
  typedef enum logic [INSTR_TYPE_W-1:0] {
    IT_R  = 4'd0,
    IT_I  = 4'd1,
    IT_S  = 4'd2,
    IT_B  = 4'd3,
    IT_U  = 4'd4,
    IT_J  = 4'd5,
    IT_Z  = 4'd6,
    IT_SH = 4'd7
  } instr_type_e;

  // Raw immediate field widths before extension.
  localparam int I_W = 12;
  localparam int S_W = 12;
  localparam int B_W = 13;
  localparam int U_W = 32;
  localparam int J_W = 21;
  localparam int Z_W = 5;

  // Number of instruction bits carried (instr[31:7]).
  localparam int INSTR_W = 25;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Producer/consumer bundle for the immediate-generation stage.
interface imm_gen_stage_if
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [INSTR_W-1:0]      instr;
  logic [INSTR_TYPE_W-1:0] instr_type;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         simm;
  logic                    illegal;
  logic [TAG_W-1:0]        out_tag;

  // Stage view.
  modport slave (
    input  flush, in_valid, instr, instr_type, in_tag, out_ready,
    output in_ready, out_valid, simm, illegal, out_tag
  );

  // Environment view (producer and consumer).
  modport master (
    output flush, in_valid, instr, instr_type, in_tag, out_ready,
    input  in_ready, out_valid, simm, illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_stage_imm_extract.sv
// Combinational immediate extraction and extension from instr[31:7].
module imm_extract
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [INSTR_W-1:0]      instr,
  input  logic [INSTR_TYPE_W-1:0] instr_type,
  output logic [XLEN-1:0]         simm,
  output logic                    illegal
);
  // instr[0] is architectural bit 7; offset by LSB to keep ISA bit numbers readable.
  localparam int LSB     = 7;
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam int I_EXT   = XLEN - I_W;
  localparam int S_EXT   = XLEN - S_W;
  localparam int B_EXT   = XLEN - B_W;
  localparam int U_EXT   = XLEN - U_W;
  localparam int J_EXT   = XLEN - J_W;
  localparam int Z_EXT   = XLEN - Z_W;
  localparam int SH_EXT  = XLEN - SHAMT_W;

  logic [I_W-1:0]     i_fld_s;
  logic [S_W-1:0]     s_fld_s;
  logic [B_W-1:0]     b_fld_s;
  logic [U_W-1:0]     u_fld_s;
  logic [J_W-1:0]     j_fld_s;
  logic [Z_W-1:0]     z_fld_s;
  logic [SHAMT_W-1:0] sh_fld_s;
  logic [XLEN-1:0]    u_imm_s;

  assign i_fld_s  = instr[31-LSB:20-LSB];
  assign s_fld_s  = {instr[31-LSB:25-LSB], instr[11-LSB:7-LSB]};
  assign b_fld_s  = {instr[31-LSB], instr[7-LSB], instr[30-LSB:25-LSB],
                     instr[11-LSB:8-LSB], 1'b0};
  assign u_fld_s  = {instr[31-LSB:12-LSB], 12'h000};
  assign j_fld_s  = {instr[31-LSB], instr[19-LSB:12-LSB], instr[20-LSB],
                     instr[30-LSB:21-LSB], 1'b0};
  assign z_fld_s  = instr[19-LSB:15-LSB];
  assign sh_fld_s = instr[20-LSB+SHAMT_W-1:20-LSB];

  // U already fills 32 bits, so on a 32-bit datapath there is nothing to extend.
  if (U_EXT > 0) begin : g_u_ext
    assign u_imm_s = {{U_EXT{u_fld_s[U_W-1]}}, u_fld_s};
  end else begin : g_u_flat
    assign u_imm_s = u_fld_s;
  end

  // Select and extend the immediate for the requested format.
  always_comb begin
    simm    = {XLEN{1'b0}};
    illegal = 1'b0;
    case (instr_type)
      IT_I:    simm = {{I_EXT{i_fld_s[I_W-1]}}, i_fld_s};
      IT_S:    simm = {{S_EXT{s_fld_s[S_W-1]}}, s_fld_s};
      IT_B:    simm = {{B_EXT{b_fld_s[B_W-1]}}, b_fld_s};
      IT_U:    simm = u_imm_s;
      IT_J:    simm = {{J_EXT{j_fld_s[J_W-1]}}, j_fld_s};
      IT_Z:    simm = {{Z_EXT{1'b0}}, z_fld_s};
      IT_SH:   simm = {{SH_EXT{1'b0}}, sh_fld_s};
      IT_R:    simm = {XLEN{1'b0}};
      default: begin
        simm    = {XLEN{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: extracts at push time and buffers
// {simm, illegal, tag} in a 2-entry FIFO with valid/ready and flush.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_stage_if.slave bus
);
  if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [1:0]       count_r;
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic [XLEN-1:0]  simm_mem_r [2];
  logic             ill_mem_r  [2];
  logic [TAG_W-1:0] tag_mem_r  [2];

  logic             push_s;
  logic             pop_s;
  logic [XLEN-1:0]  ext_simm_s;
  logic             ext_ill_s;

  imm_extract #(.XLEN(XLEN)) u_imm_extract (
    .instr      (bus.instr),
    .instr_type (bus.instr_type),
    .simm       (ext_simm_s),
    .illegal    (ext_ill_s)
  );

  // Ready/valid come only from the registered occupancy.
  assign bus.in_ready  = (count_r != 2'd2);
  assign bus.out_valid = (count_r != 2'd0);
  assign push_s        = bus.in_valid & bus.in_ready;
  assign pop_s         = bus.out_valid & bus.out_ready;

  // Occupancy and pointer update; flush wins over any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else if (bus.flush) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        simm_mem_r[i] <= {XLEN{1'b0}};
        ill_mem_r[i]  <= 1'b0;
        tag_mem_r[i]  <= {TAG_W{1'b0}};
      end
    end else if (push_s && !bus.flush) begin
      simm_mem_r[wr_ptr_r] <= ext_simm_s;
      ill_mem_r[wr_ptr_r]  <= ext_ill_s;
      tag_mem_r[wr_ptr_r]  <= bus.in_tag;
    end
  end

  // Head payload, forced to zero while the FIFO is empty.
  always_comb begin
    if (count_r != 2'd0) begin
      bus.simm    = simm_mem_r[rd_ptr_r];
      bus.illegal = ill_mem_r[rd_ptr_r];
      bus.out_tag = tag_mem_r[rd_ptr_r];
    end else begin
      bus.simm    = {XLEN{1'b0}};
      bus.illegal = 1'b0;
      bus.out_tag = {TAG_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench: randomized traffic against a queue-based reference
// model, plus directed format, backpressure, flush and reset cases.
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  typedef struct {
    logic [63:0] simm;
    logic        ill;
    logic [63:0] tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  ent_t q[$];

  imm_gen_stage_if #(.XLEN(64), .TAG_W(64)) if64 ();
  imm_gen_stage_if #(.XLEN(32), .TAG_W(8))  if32 ();

  imm_gen_stage #(.XLEN(64), .TAG_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));
  imm_gen_stage #(.XLEN(32), .TAG_W(8))  dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Immediate from the format definitions using plain integer arithmetic.
  function automatic logic [64:0] ref_imm(input logic [31:0] w, input logic [3:0] t, input int xlen);
    longint unsigned u = 64'(w);
    longint unsigned f = 64'd0;
    int bits = 1;
    bit sgn = 1'b1;
    bit ill = 1'b0;
    case (t)
      IT_I:  begin f = u >> 20; bits = 12; end
      IT_S:  begin f = ((u >> 25) << 5) | ((u >> 7) & 64'd31); bits = 12; end
      IT_B:  begin
        f = (((u >> 31) & 64'd1) << 12) | (((u >> 7) & 64'd1) << 11) |
            (((u >> 25) & 64'd63) << 5) | (((u >> 8) & 64'd15) << 1);
        bits = 13;
      end
      IT_U:  begin f = u & 64'hFFFF_F000; bits = 32; end
      IT_J:  begin
        f = (((u >> 31) & 64'd1) << 20) | (((u >> 12) & 64'd255) << 12) |
            (((u >> 20) & 64'd1) << 11) | (((u >> 21) & 64'd1023) << 1);
        bits = 21;
      end
      IT_Z:  begin f = (u >> 15) & 64'd31; sgn = 1'b0; end
      IT_SH: begin f = (u >> 20) & ((xlen == 64) ? 64'd63 : 64'd31); sgn = 1'b0; end
      IT_R:  begin f = 64'd0; sgn = 1'b0; end
      default: begin f = 64'd0; sgn = 1'b0; ill = 1'b1; end
    endcase
    if (sgn && (f >= (64'd1 << (bits - 1)))) f = f - (64'd1 << bits);
    if (xlen == 32) f = f & 64'hFFFF_FFFF;
    return {ill, f};
  endfunction

  // One cycle on the 64-bit stage: check outputs, drive inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] w, input logic [3:0] t,
                      input logic [63:0] tag, input bit ordy, input bit fl);
    bit exp_ready;
    bit do_push;
    bit do_pop;
    logic [64:0] r;
    ent_t e;
    ent_t dummy;
    @(negedge clk);
    exp_ready = (q.size() != 2);
    chk("in_ready", if64.in_ready, exp_ready);
    chk("out_valid", if64.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("simm", if64.simm, q[0].simm);
      chk("illegal", if64.illegal, q[0].ill);
      chk("out_tag", if64.out_tag, q[0].tag);
    end else begin
      chk("simm_empty", if64.simm, 64'd0);
      chk("illegal_empty", if64.illegal, 1'b0);
      chk("tag_empty", if64.out_tag, 64'd0);
    end
    if64.in_valid   = v;
    if64.instr      = w[31:7];
    if64.instr_type = t;
    if64.in_tag     = tag;
    if64.out_ready  = ordy;
    if64.flush      = fl;
    do_push = v && exp_ready;
    do_pop  = (q.size() != 0) && ordy;
    r = ref_imm(w, t, 64);
    e.simm = r[63:0];
    e.ill  = r[64];
    e.tag  = tag;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) dummy = q.pop_front();
      if (do_push) q.push_back(e);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  t;
    logic [64:0] r;
    if64.flush = 1'b0; if64.in_valid = 1'b0; if64.instr = 25'd0;
    if64.instr_type = 4'd0; if64.in_tag = 64'd0; if64.out_ready = 1'b1;
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.instr = 25'd0;
    if32.instr_type = 4'd0; if32.in_tag = 8'd0; if32.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", if64.out_valid, 1'b0);
    chk("rst_in_ready", if64.in_ready, 1'b1);
    chk("rst_simm", if64.simm, 64'd0);
    chk("rst_tag", if64.out_tag, 64'd0);
    chk("rst_illegal", if64.illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed formats, one-cycle latency
    step(1'b1, 32'hFFF0_0093, IT_I, 64'd100, 1'b1, 1'b0);
    #1; chk("I_imm", if64.simm, 64'hFFFF_FFFF_FFFF_FFFF); chk("I_ill", if64.illegal, 1'b0);
    step(1'b1, 32'hFE00_0EE3, IT_B, 64'd101, 1'b1, 1'b0);
    #1; chk("B_imm", if64.simm, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h8000_00B7, IT_U, 64'd102, 1'b1, 1'b0);
    #1; chk("U_imm", if64.simm, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'h000F_8000, IT_Z, 64'd103, 1'b1, 1'b0);
    #1; chk("Z_imm", if64.simm, 64'h1F);
    step(1'b1, 32'h03F0_0000, IT_SH, 64'd104, 1'b1, 1'b0);
    #1; chk("SH_imm", if64.simm, 64'h3F);
    step(1'b1, 32'hFFFF_FFFF, 4'd12, 64'd105, 1'b1, 1'b0);
    #1; chk("bad_imm", if64.simm, 64'd0); chk("bad_ill", if64.illegal, 1'b1);
    step(1'b0, 32'd0, IT_R, 64'd0, 1'b1, 1'b0);

    // Backpressure: tags 1,2,3 offered while the consumer stalls
    step(1'b1, 32'h0010_0013, IT_I, 64'd1, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0013, IT_I, 64'd2, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0013, IT_I, 64'd3, 1'b0, 1'b0);
    #1; chk("bp_full", if64.in_ready, 1'b0); chk("bp_head1", if64.out_tag, 64'd1);
    step(1'b1, 32'h0030_0013, IT_I, 64'd3, 1'b0, 1'b0);
    #1; chk("bp_stable", if64.out_tag, 64'd1); chk("bp_simm1", if64.simm, 64'd1);
    step(1'b1, 32'h0030_0013, IT_I, 64'd3, 1'b1, 1'b0);
    #1; chk("bp_head2", if64.out_tag, 64'd2); chk("bp_cnt1", if64.in_ready, 1'b1);
    step(1'b1, 32'h0030_0013, IT_I, 64'd3, 1'b1, 1'b0);
    #1; chk("bp_head3", if64.out_tag, 64'd3); chk("bp_valid", if64.out_valid, 1'b1);
    step(1'b0, 32'd0, IT_R, 64'd0, 1'b1, 1'b0);
    #1; chk("bp_drained", if64.out_valid, 1'b0);

    // Flush while full with in_valid high, then flush dropping a live push
    step(1'b1, 32'h0010_0013, IT_I, 64'd10, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0013, IT_I, 64'd11, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0013, IT_I, 64'd12, 1'b0, 1'b1);
    #1; chk("fl_valid", if64.out_valid, 1'b0); chk("fl_ready", if64.in_ready, 1'b1);
    step(1'b1, 32'h0010_0013, IT_I, 64'd13, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0013, IT_I, 64'd14, 1'b1, 1'b1);
    #1; chk("fl_drop", if64.out_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
           {$urandom, $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-stream
    step(1'b1, 32'h0010_0013, IT_I, 64'd20, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0013, IT_I, 64'd21, 1'b0, 1'b0);
    @(negedge clk);
    if64.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", if64.out_valid, 1'b0);
    chk("arst_ready", if64.in_ready, 1'b1);
    chk("arst_simm", if64.simm, 64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    step(1'b0, 32'd0, IT_R, 64'd0, 1'b1, 1'b0);

    // 32-bit datapath: each cycle pushes one entry and pops the previous
    @(negedge clk);
    if32.in_valid = 1'b1; if32.instr = 25'(32'h8000_00B7 >> 7); if32.instr_type = IT_U;
    @(posedge clk); #1;
    chk("U32_imm", if32.simm, 32'h8000_0000);
    @(negedge clk);
    if32.instr = 25'(32'h03F0_0000 >> 7); if32.instr_type = IT_SH;
    @(posedge clk); #1;
    chk("SH32_imm", if32.simm, 32'h1F);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      w = $urandom;
      t = 4'($urandom_range(0, 15));
      if32.instr = w[31:7]; if32.instr_type = t;
      r = ref_imm(w, t, 32);
      @(posedge clk); #1;
      chk("rnd32_simm", if32.simm, r[31:0]);
      chk("rnd32_ill", if32.illegal, r[64]);
    end
    @(negedge clk);
    if32.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
